// File: rtl/glb_block_source.sv
// glb_block_source: streams length-prefixed blocks from a read buffer through a 2-entry output FIFO.
module glb_block_source #(
  parameter int ADDR_WIDTH = 9,
  parameter int TX_NUM = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_ren,
  input  logic [16:0]           mem_rdata,
  output logic [16:0]           data,
  output logic                  valid,
  input  logic                  ready,
  output logic                  done
);
  localparam int BW = TX_NUM > 1 ? $clog2(TX_NUM) : 1;
  typedef enum logic [1:0] {IDLE, HDR, DATA, DONE} state_t;
  state_t state, state_n;
  logic [ADDR_WIDTH-1:0] addr, addr_n;
  logic [BW-1:0] blk, blk_n;
  logic [15:0] rem, rem_n;
  logic hdr_pend, hdr_pend_n, inflight, issue;
  logic [16:0] fifo [2];
  logic wp, rp;
  logic [1:0] count;
  logic [2:0] occ;
  logic pop, room, last_blk;
  // occupancy after this cycle's pop and pending return; keeps one word per cycle with ready high
  assign occ = 3'(count) + 3'(inflight) - 3'(pop);
  assign room = occ < 3'd2;
  assign pop = valid & ready;
  assign last_blk = blk == BW'(TX_NUM - 1);
  assign valid = count != 2'd0;
  assign data = valid ? fifo[rp] : '0;
  assign done = state == DONE && !valid && !inflight;
  assign mem_addr = addr;
  assign mem_ren = issue & ~flush;
  always_comb begin
    state_n = state;
    addr_n = addr;
    blk_n = blk;
    rem_n = rem;
    hdr_pend_n = hdr_pend;
    issue = 1'b0;
    case (state)
      IDLE, DONE: if (start) begin
        state_n = HDR;
        addr_n = '0;
        blk_n = '0;
      end
      HDR: begin
        issue = !hdr_pend && room;
        if (hdr_pend) begin
          hdr_pend_n = 1'b0;
          rem_n = mem_rdata[15:0];
          state_n = mem_rdata[15:0] != 16'd0 ? DATA : last_blk ? DONE : HDR;
          blk_n = mem_rdata[15:0] != 16'd0 ? blk : blk + 1'b1;
        end else if (room) hdr_pend_n = 1'b1;
      end
      DATA: begin
        issue = room;
        if (room) begin
          rem_n = rem - 1'b1;
          if (rem == 16'd1) begin
            blk_n = blk + 1'b1;
            state_n = last_blk ? DONE : HDR;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (issue) addr_n = addr + 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      addr <= '0;
      blk <= '0;
      rem <= '0;
      hdr_pend <= 1'b0;
      inflight <= 1'b0;
      fifo[0] <= '0;
      fifo[1] <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      count <= '0;
    end else if (flush) begin
      state <= IDLE;
      addr <= '0;
      blk <= '0;
      rem <= '0;
      hdr_pend <= 1'b0;
      inflight <= 1'b0;
      fifo[0] <= '0;
      fifo[1] <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      count <= '0;
    end else begin
      state <= state_n;
      addr <= addr_n;
      blk <= blk_n;
      rem <= rem_n;
      hdr_pend <= hdr_pend_n;
      inflight <= mem_ren;
      if (inflight) fifo[wp] <= mem_rdata & 17'h0FFFF;
      if (inflight) wp <= ~wp;
      if (pop) rp <= ~rp;
      count <= count + {1'b0, inflight} - {1'b0, pop};
    end
  end
endmodule
